// File: rtl/echo_pulse_meter.sv
// Measures the high time of an asynchronous echo pulse in prescaled ticks.
// Optional macro ECHO_GLITCH_FILTER_EN adds a FILT_LEN-cycle debounce after the synchronizer.
module echo_pulse_meter #(
    parameter int unsigned TICK_DIV      = 100,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned TIMEOUT_TICKS = 38000,
    parameter int unsigned FILT_LEN      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             echo,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] width_ticks
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    if (TICK_DIV < 2 || FILT_LEN == 0 || TIMEOUT_TICKS == 0 ||
        64'(TIMEOUT_TICKS) >= (64'd1 << CNT_W)) begin : g_param_check
        $error("echo_pulse_meter: invalid parameter set");
    end

    logic sync1, sync2;
    logic echo_lvl, echo_lvl_d;
    logic rise, fall;

    // Two-flop synchronizer plus delayed level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            echo_lvl_d <= 1'b0;
        end else begin
            sync1      <= echo;
            sync2      <= sync1;
            echo_lvl_d <= echo_lvl;
        end
    end

`ifdef ECHO_GLITCH_FILTER_EN
    localparam int unsigned FILT_W = $clog2(FILT_LEN + 1);

    logic              filt;
    logic [FILT_W-1:0] filt_cnt;

    // Level follows the synced input only after FILT_LEN consecutive differing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            filt     <= 1'b0;
            filt_cnt <= '0;
        end else if (sync2 != filt) begin
            if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
                filt     <= sync2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    assign echo_lvl = filt;
`else
    assign echo_lvl = sync2;
`endif

    assign rise = echo_lvl & ~echo_lvl_d;
    assign fall = ~echo_lvl & echo_lvl_d;

    state_t             state, state_next;
    logic [PRESC_W-1:0] presc, presc_next;
    logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
    logic               tick;
    logic               busy_next, valid_next, timeout_next;
    logic [CNT_W-1:0]   width_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            presc       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            width_ticks <= '0;
        end else begin
            state       <= state_next;
            presc       <= presc_next;
            cnt         <= cnt_next;
            busy        <= busy_next;
            valid       <= valid_next;
            timeout     <= timeout_next;
            width_ticks <= width_next;
        end
    end

    assign tick    = (presc == PRESC_W'(TICK_DIV - 1));
    assign cnt_inc = cnt + CNT_W'(tick);

    // Next state, prescaler/tick count and result registers
    always_comb begin
        state_next   = state;
        presc_next   = presc;
        cnt_next     = cnt;
        timeout_next = timeout;
        width_next   = width_ticks;

        if (state == ARMED || state == MEASURE) begin
            presc_next = tick ? '0 : presc + PRESC_W'(1);
            cnt_next   = cnt_inc;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ARMED;
                    presc_next = '0;
                    cnt_next   = '0;
                end
            end
            ARMED: begin
                if (rise) begin
                    state_next = MEASURE;
                    presc_next = '0;
                    cnt_next   = '0;
                end else if (tick && cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                    width_next   = '0;
                end
            end
            MEASURE: begin
                // A fall on the timeout tick still counts as a real measurement
                if (fall) begin
                    state_next   = DONE;
                    timeout_next = 1'b0;
                    width_next   = cnt_inc;
                end else if (tick && cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                    width_next   = CNT_W'(TIMEOUT_TICKS);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next  = (state_next == ARMED) || (state_next == MEASURE);
        valid_next = (state_next == DONE);
    end

endmodule
